// File: rtl/cpu_pkg.sv
// Shared CPU constants: RV32 opcode values and the hazard controller's state encoding.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_FLUSH2   = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline is master, the controller slave.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic             D_VALID;
  logic [REG_W-1:0] D_REG_S1;
  logic [REG_W-1:0] D_REG_S2;
  logic             E_VALID;
  logic             E_IS_LOAD;
  logic [REG_W-1:0] E_REG_D;
  logic             E_JUMP;
  logic             M_MEM_REQ;
  logic             M_MEM_READY;
  logic             STALL;
  logic             FLUSH;
  logic             BUBBLE;
  state_t           STATE;
  logic             WDT_ERR;

  modport master (
    output D_VALID, D_REG_S1, D_REG_S2, E_VALID, E_IS_LOAD, E_REG_D,
           E_JUMP, M_MEM_REQ, M_MEM_READY,
    input  STALL, FLUSH, BUBBLE, STATE, WDT_ERR
  );

  modport slave (
    input  D_VALID, D_REG_S1, D_REG_S2, E_VALID, E_IS_LOAD, E_REG_D,
           E_JUMP, M_MEM_REQ, M_MEM_READY,
    output STALL, FLUSH, BUBBLE, STATE, WDT_ERR
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the load in execute writes a register decode is reading.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_reg_s1,
  input  logic [REG_W-1:0] d_reg_s2,
  input  logic             e_valid,
  input  logic             e_is_load,
  input  logic [REG_W-1:0] e_reg_d,
  output logic             hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = e_valid & e_is_load & (e_reg_d != '0) & d_valid &
                  ((e_reg_d == d_reg_s1) | (e_reg_d == d_reg_s2));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stall, jump flush and load-use bubble with fixed priority.
// Optional watchdog on long memory waits is built when HAZARD_CTRL_WDT_EN is defined.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int WDT_LIMIT = 256
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_ctrl_if.slave  bus
);

  logic   stall;
  logic   flush;
  logic   hazard;
  logic   wdt_err;
  state_t state_reg;
  state_t state_next;

  assign stall = bus.M_MEM_REQ & ~bus.M_MEM_READY;

  hazard_detect u_detect (
    .d_valid   (bus.D_VALID),
    .d_reg_s1  (bus.D_REG_S1),
    .d_reg_s2  (bus.D_REG_S2),
    .e_valid   (bus.E_VALID),
    .e_is_load (bus.E_IS_LOAD),
    .e_reg_d   (bus.E_REG_D),
    .hazard    (hazard)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // A jump seen while stalled stays in execute, so it is taken the first unstalled cycle
  always_comb begin
    state_next = ST_RUN;
    case (state_reg)
      ST_RUN, ST_MEM_WAIT: begin
        if (stall)            state_next = ST_MEM_WAIT;
        else if (bus.E_JUMP)  state_next = ST_FLUSH2;
        else                  state_next = ST_RUN;
      end
      ST_FLUSH2: state_next = stall ? ST_FLUSH2 : ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    flush = 1'b0;
    case (state_reg)
      ST_RUN, ST_MEM_WAIT: flush = ~stall & bus.E_JUMP;
      ST_FLUSH2:           flush = ~stall;
      default:             flush = 1'b0;
    endcase
  end

  assign bus.STALL   = ~RST & stall;
  assign bus.FLUSH   = ~RST & flush;
  assign bus.BUBBLE  = ~RST & hazard & ~stall & ~flush;
  assign bus.STATE   = RST ? ST_RUN : state_reg;
  assign bus.WDT_ERR = ~RST & wdt_err;

`ifdef HAZARD_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT) + 1;

  logic [WDT_W-1:0] wdt_cnt_reg;
  logic             wdt_err_reg;

  // Counter saturates at the limit; the error flag is sticky until reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdt_cnt_reg <= '0;
      wdt_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_MEM_WAIT && state_next == ST_MEM_WAIT) begin
        if (wdt_cnt_reg != WDT_W'(WDT_LIMIT))
          wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
      end else begin
        wdt_cnt_reg <= '0;
      end
      if (state_reg == ST_MEM_WAIT && wdt_cnt_reg == WDT_W'(WDT_LIMIT - 1))
        wdt_err_reg <= 1'b1;
    end
  end

  assign wdt_err = wdt_err_reg;
`else
  // The limit only matters when the watchdog is built
  assign wdt_err = 1'b0 & (WDT_LIMIT != 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, memory wait, jump flush, reset abort, watchdog.
module tb_hazard_ctrl;
  import cpu_pkg::*;

`ifdef HAZARD_CTRL_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.WDT_LIMIT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.D_VALID = 0; bus.D_REG_S1 = 0; bus.D_REG_S2 = 0;
    bus.E_VALID = 0; bus.E_IS_LOAD = 0; bus.E_REG_D = 0;
    bus.E_JUMP = 0;  bus.M_MEM_REQ = 0; bus.M_MEM_READY = 0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    bus.E_VALID = 1; bus.E_IS_LOAD = 1; bus.E_REG_D = rd;
    bus.D_VALID = 1; bus.D_REG_S1 = s1; bus.D_REG_S2 = s2;
  endtask

  // Compare all five outputs against hand-derived values
  task automatic expect_out(input string tag, input logic st, input logic fl,
                            input logic bu, input logic [1:0] state, input logic wd);
    #1;
    check({tag, ".stall"},  bus.STALL,   st);
    check({tag, ".flush"},  bus.FLUSH,   fl);
    check({tag, ".bubble"}, bus.BUBBLE,  bu);
    check({tag, ".state"},  bus.STATE,   state);
    check({tag, ".wdt"},    bus.WDT_ERR, wd);
  endtask

  initial begin
    idle();
    RST = 1;
    // Everything that could raise an output is active while reset is held
    load_use(5'd5, 5'd0, 5'd5);
    bus.E_JUMP = 1; bus.M_MEM_REQ = 1;
    #2 expect_out("rst", 0, 0, 0, 0, 0);
    cyc();
    expect_out("rst_hold", 0, 0, 0, 0, 0);
    idle();
    RST = 0;
    cyc();

    // Load-use
    load_use(5'd5, 5'd3, 5'd5);
    expect_out("lu_s2", 0, 0, 1, 0, 0);
    cyc();
    bus.E_VALID = 0;
    expect_out("lu_after", 0, 0, 0, 0, 0);
    load_use(5'd0, 5'd0, 5'd0);
    expect_out("lu_x0", 0, 0, 0, 0, 0);
    load_use(5'd7, 5'd7, 5'd1);
    expect_out("lu_s1", 0, 0, 1, 0, 0);
    bus.E_IS_LOAD = 0;
    expect_out("lu_noload", 0, 0, 0, 0, 0);
    bus.E_IS_LOAD = 1; bus.D_VALID = 0;
    expect_out("lu_dinv", 0, 0, 0, 0, 0);
    idle();
    cyc();

    // Memory wait: three stalled cycles, then ready
    bus.M_MEM_REQ = 1;
    expect_out("mw0", 1, 0, 0, 0, 0);
    cyc();
    load_use(5'd4, 5'd4, 5'd0);
    expect_out("mw1", 1, 0, 0, 1, 0);
    cyc();
    expect_out("mw2", 1, 0, 0, 1, 0);
    cyc();
    idle();
    bus.M_MEM_REQ = 1; bus.M_MEM_READY = 1;
    expect_out("mw_rdy", 0, 0, 0, 1, 0);
    cyc();
    idle();
    expect_out("mw_done", 0, 0, 0, 0, 0);

    // Jump with simultaneous load-use: two flush cycles, no bubble
    load_use(5'd9, 5'd9, 5'd2);
    bus.E_JUMP = 1;
    expect_out("j0", 0, 1, 0, 0, 0);
    cyc();
    bus.E_JUMP = 0;
    expect_out("j1", 0, 1, 0, 2, 0);
    cyc();
    idle();
    expect_out("j2", 0, 0, 0, 0, 0);
    cyc();

    // Jump deferred across a two-cycle stall
    bus.E_JUMP = 1; bus.M_MEM_REQ = 1;
    expect_out("js0", 1, 0, 0, 0, 0);
    cyc();
    expect_out("js1", 1, 0, 0, 1, 0);
    cyc();
    bus.M_MEM_READY = 1;
    expect_out("js_rdy", 0, 1, 0, 1, 0);
    cyc();
    idle();
    expect_out("js_f2", 0, 1, 0, 2, 0);
    cyc();
    expect_out("js_end", 0, 0, 0, 0, 0);

    // Stall arriving in FLUSH2 holds the second flush cycle
    bus.E_JUMP = 1;
    expect_out("fs0", 0, 1, 0, 0, 0);
    cyc();
    idle();
    bus.M_MEM_REQ = 1;
    expect_out("fs_hold", 1, 0, 0, 2, 0);
    cyc();
    expect_out("fs_hold2", 1, 0, 0, 2, 0);
    bus.M_MEM_READY = 1;
    expect_out("fs_rel", 0, 1, 0, 2, 0);
    cyc();
    idle();
    expect_out("fs_end", 0, 0, 0, 0, 0);

    // Reset during FLUSH2
    bus.E_JUMP = 1;
    cyc();
    bus.E_JUMP = 0;
    expect_out("rm_f2", 0, 1, 0, 2, 0);
    RST = 1; bus.M_MEM_REQ = 1;
    expect_out("rm_rst", 0, 0, 0, 0, 0);
    cyc();
    expect_out("rm_rst2", 0, 0, 0, 0, 0);
    RST = 0; idle();
    expect_out("rm_after", 0, 0, 0, 0, 0);
    cyc();

    // Watchdog: ready never comes
    bus.M_MEM_REQ = 1;
    expect_out("wd0", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      expect_out($sformatf("wd%0d", i), 1, 0, 0, 1, WDT_ON && i == 5);
    end
    bus.M_MEM_READY = 1;
    expect_out("wd_rdy", 0, 0, 0, 1, WDT_ON);
    cyc();
    idle();
    expect_out("wd_sticky", 0, 0, 0, 0, WDT_ON);
    cyc();
    expect_out("wd_sticky2", 0, 0, 0, 0, WDT_ON);
    RST = 1;
    expect_out("wd_rst", 0, 0, 0, 0, 0);
    cyc();
    RST = 0;
    expect_out("wd_clr", 0, 0, 0, 0, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
